block_store_arbiter: RTL and testbench
======================================

Name: block_store_arbiter

Overview:
- Shares the single-port block-alive RAM (NUM_BLOCKS x 1 bit) between two clients.
- Renderer read port: owns the RAM during active video.
- Game-logic port: query or clear one block via req/ack; served only during vertical blanking.
- Sequences the level refill (all blocks alive), both after reset and on request, and tracks the alive-block count so the game logic can detect level completion.

Parameters:
NUM_BLOCKS, 128, number of blocks in the RAM
ADDR_W, 7, block address width
COUNT_W, 8, alive-counter width; must hold NUM_BLOCKS

Ports:
CLK  in  1  system clock (pixel clock)
RESET  in  1  asynchronous, active-high reset
IN_VBLANK  in  1  high while renderer Y >= 600; deasserts at Y=0, X=0
R_ADDR  in  ADDR_W  renderer block address
R_ALIVE  out  1  alive bit for the R_ADDR presented one cycle earlier
G_REQ  in  1  game request; held high until G_ACK
G_CLEAR  in  1  1 = clear block, 0 = query; stable while G_REQ is high
G_ADDR  in  ADDR_W  game block address; stable while G_REQ is high
G_ACK  out  1  one-cycle pulse; transaction complete
G_ALIVE  out  1  block state before the operation; valid with G_ACK
REFILL_REQ  in  1  pulse: set every block alive
REFILL_BUSY  out  1  high while a refill is pending or running
ALIVE_COUNT  out  COUNT_W  number of alive blocks
MEM_ADDR  out  ADDR_W  RAM address
MEM_WE  out  1  RAM write enable
MEM_WDATA  out  1  RAM write data
MEM_RDATA  in  1  RAM read data; one-cycle synchronous read latency

Behaviour:
- Reset values:
  - G_ACK=0, G_ALIVE=0, MEM_WE=0, MEM_WDATA=0.
  - ALIVE_COUNT=0, REFILL_BUSY=1, refill index=0.
  - State=REFILL, i.e. an automatic refill after every reset. RAM contents are undefined until that refill completes.
- States:
  - IDLE
  - G_READ: MEM_ADDR=G_ADDR, read issued.
  - G_RESP: MEM_RDATA valid.
    - Query: G_ACK=1, G_ALIVE=MEM_RDATA, next state IDLE.
    - Clear with MEM_RDATA=1: go to G_WRITE.
    - Clear with MEM_RDATA=0: ack immediately, count unchanged.
  - G_WRITE: MEM_WE=1, MEM_WDATA=0 at G_ADDR; G_ACK=1, G_ALIVE=1; ALIVE_COUNT decrements on the same edge; next state IDLE.
  - REFILL: each cycle with IN_VBLANK=1, write 1 at the index and increment the index. After index NUM_BLOCKS-1 is written: ALIVE_COUNT=NUM_BLOCKS, REFILL_BUSY=0, next state IDLE.
- Latency:
  - Query: ack 2 cycles after G_READ is entered.
  - Clear of an alive block: ack 3 cycles after G_READ is entered.
- IN_VBLANK gating:
  - G_READ and refill writes start only when IN_VBLANK=1. With IN_VBLANK=0, IDLE holds and requests wait; no ack, no timeout.
  - A game transaction already in G_READ/G_RESP/G_WRITE completes even if IN_VBLANK drops. This is harmless because the block region begins at pixel row 8.
  - An in-progress refill pauses while IN_VBLANK=0 (no write, index held) and resumes on the next IN_VBLANK=1.
- MEM_ADDR mux:
  - Game address in G_READ, G_RESP and G_WRITE.
  - Refill index in REFILL while IN_VBLANK=1.
  - R_ADDR otherwise.
  - R_ALIVE is MEM_RDATA registered-through (no extra flop). The renderer accounts for one cycle of latency.
- Priority in IDLE when REFILL_REQ and G_REQ are both present: refill first, G_REQ is served afterwards.
- REFILL_REQ arriving during a game transaction is latched (REFILL_BUSY=1 next cycle) and taken on return to IDLE.
- REFILL_REQ during a refill restarts nothing; the pulse is ignored.
- ALIVE_COUNT:
  - Unsigned, never wraps.
  - Decrements only on a clear of an alive block.
  - Set to NUM_BLOCKS only at refill completion; it is not incremented per write.
  - During a refill it holds its old value until completion.
- A game request held across reset is re-served from scratch after the post-reset refill.

Decomposition:
- NUM_BLOCKS and the block-region start row go in the shared game-geometry include, used by this block and the renderer.
- State encoding is local.
- No sub-module; the refill index counter and the alive counter are simple local registers.

Test Plan:
- Release reset with IN_VBLANK=1 -> MEM_WE=1 for 128 consecutive cycles, addresses 0..127, MEM_WDATA=1; then REFILL_BUSY=0, ALIVE_COUNT=128.
- Query at G_ADDR=5 on an alive block during vblank -> G_ACK on the 2nd cycle after G_READ is entered, G_ALIVE=1, no MEM_WE, count 128.
- Clear G_ADDR=5 twice -> first ack G_ALIVE=1 with one write of 0 at address 5 and count 127; second ack G_ALIVE=0 with no write and count 127.
- Raise G_REQ with IN_VBLANK=0 for 1000 cycles -> MEM_ADDR tracks R_ADDR, R_ALIVE tracks the RAM with one-cycle lag, no G_ACK; IN_VBLANK=1 -> served.
- Refill spanning a vblank drop at index 60 -> writes pause at index 60 and resume at 60; count is 128 only after index 127 is written.
- REFILL_REQ and G_REQ (clear address 3) in the same IDLE cycle -> full refill first, then the clear is acked with G_ALIVE=1 and count 127.

Source files
------------

// File: rtl/block_store_arbiter_pkg.sv
// Shared geometry and types for the block-alive store arbiter.
//   NUM_BLOCKS : number of blocks in the level (one RAM bit each)
//   ADDR_W     : block address width
//   COUNT_W    : alive-counter width, wide enough to hold NUM_BLOCKS
package block_store_arbiter_pkg;

  localparam int unsigned NUM_BLOCKS = 128;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned COUNT_W    = 8;

  // Arbiter states; IDLE hands the RAM to the renderer.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_G_READ  = 3'd1,
    ST_G_RESP  = 3'd2,
    ST_G_WRITE = 3'd3,
    ST_REFILL  = 3'd4
  } state_t;

  // Game-logic operation payload, held stable while G_REQ is high.
  typedef struct packed {
    logic              clear;
    logic [ADDR_W-1:0] addr;
  } g_op_t;

  // True when idx addresses the final block of the level.
  function automatic logic is_last_block(input logic [ADDR_W-1:0] idx);
    return idx == ADDR_W'(NUM_BLOCKS - 1);
  endfunction

endpackage

// File: rtl/block_store_arbiter_if.sv
// Bundle of renderer, game-logic, refill and RAM signals around the arbiter.
//   slave  : arbiter view (drives acks, status and the RAM port)
//   master : environment view (renderer, game logic, RAM)
interface block_store_arbiter_if;
  import block_store_arbiter_pkg::*;

  logic               IN_VBLANK;
  logic [ADDR_W-1:0]  R_ADDR;
  logic               R_ALIVE;
  logic               G_REQ;
  logic               G_CLEAR;
  logic [ADDR_W-1:0]  G_ADDR;
  logic               G_ACK;
  logic               G_ALIVE;
  logic               REFILL_REQ;
  logic               REFILL_BUSY;
  logic [COUNT_W-1:0] ALIVE_COUNT;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic               MEM_WE;
  logic               MEM_WDATA;
  logic               MEM_RDATA;

  modport slave (
    input  IN_VBLANK, R_ADDR, G_REQ, G_CLEAR, G_ADDR, REFILL_REQ, MEM_RDATA,
    output R_ALIVE, G_ACK, G_ALIVE, REFILL_BUSY, ALIVE_COUNT,
           MEM_ADDR, MEM_WE, MEM_WDATA
  );

  modport master (
    output IN_VBLANK, R_ADDR, G_REQ, G_CLEAR, G_ADDR, REFILL_REQ, MEM_RDATA,
    input  R_ALIVE, G_ACK, G_ALIVE, REFILL_BUSY, ALIVE_COUNT,
           MEM_ADDR, MEM_WE, MEM_WDATA
  );

endinterface

// File: rtl/block_store_arbiter.sv
// Arbitrates the single-port block-alive RAM between the renderer (active
// video) and the game logic (vertical blanking only), sequences level refills
// and tracks the number of alive blocks.
// Ports:
//   CLK   : pixel clock
//   RESET : asynchronous active-high reset; triggers an automatic refill
//   bus   : block_store_arbiter_if.slave (renderer read, game req/ack,
//           refill request/busy, alive count, RAM port)
module block_store_arbiter
  import block_store_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  block_store_arbiter_if.slave  bus
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               alive_q, alive_d;
  logic               rst_done_q;

  logic [ADDR_W-1:0]  mem_addr_c;
  logic               mem_we_c;
  logic               mem_wdata_c;
  g_op_t              g_op_c;

  assign g_op_c = '{clear: bus.G_CLEAR, addr: bus.G_ADDR};

  // State and bookkeeping registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_REFILL;
      idx_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      alive_q    <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      alive_q    <= alive_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next-state, RAM port mux and ack generation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    alive_d     = 1'b0;
    mem_addr_c  = bus.R_ADDR;
    mem_we_c    = 1'b0;
    mem_wdata_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Refill wins over a simultaneous game request. The ack_q guard stops
        // a request still high in the ack cycle from being served twice.
        if (busy_q || bus.REFILL_REQ) begin
          busy_d  = 1'b1;
          state_d = ST_REFILL;
        end else if (bus.G_REQ && !ack_q && bus.IN_VBLANK) begin
          state_d = ST_G_READ;
        end
      end

      ST_G_READ: begin
        mem_addr_c = g_op_c.addr;
        busy_d     = busy_q | bus.REFILL_REQ;
        state_d    = ST_G_RESP;
      end

      ST_G_RESP: begin
        mem_addr_c = g_op_c.addr;
        busy_d     = busy_q | bus.REFILL_REQ;
        if (g_op_c.clear && bus.MEM_RDATA) begin
          state_d = ST_G_WRITE;
        end else begin
          ack_d   = 1'b1;
          alive_d = bus.MEM_RDATA;
          state_d = ST_IDLE;
        end
      end

      ST_G_WRITE: begin
        mem_addr_c  = g_op_c.addr;
        mem_we_c    = 1'b1;
        mem_wdata_c = 1'b0;
        busy_d      = busy_q | bus.REFILL_REQ;
        ack_d       = 1'b1;
        alive_d     = 1'b1;
        if (count_q != '0) begin
          count_d = count_q - COUNT_W'(1);
        end
        state_d = ST_IDLE;
      end

      ST_REFILL: begin
        // Writes advance only in vblank and never while reset is asserted or
        // in the first cycle after it; REFILL_REQ is ignored here.
        if (bus.IN_VBLANK && rst_done_q) begin
          mem_addr_c  = idx_q;
          mem_we_c    = 1'b1;
          mem_wdata_c = 1'b1;
          if (is_last_block(idx_q)) begin
            idx_d   = '0;
            count_d = COUNT_W'(NUM_BLOCKS);
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.MEM_ADDR    = mem_addr_c;
  assign bus.MEM_WE      = mem_we_c;
  assign bus.MEM_WDATA   = mem_wdata_c;
  // Renderer sees the synchronous RAM output directly (one cycle behind R_ADDR).
  assign bus.R_ALIVE     = bus.MEM_RDATA;
  assign bus.G_ACK       = ack_q;
  assign bus.G_ALIVE     = alive_q;
  assign bus.REFILL_BUSY = busy_q;
  assign bus.ALIVE_COUNT = count_q;

endmodule

// File: tb/tb_block_store_arbiter.sv
// Directed bench for block_store_arbiter with a behavioural 128x1 sync RAM.
module tb_block_store_arbiter;
  import block_store_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  block_store_arbiter_if bus ();

  block_store_arbiter dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // RAM model: one-cycle read latency, read-before-write.
  logic ram [NUM_BLOCKS];
  logic rdata_q;
  always @(posedge CLK) begin
    if (bus.MEM_WE) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
    rdata_q <= ram[bus.MEM_ADDR];
  end
  assign bus.MEM_RDATA = rdata_q;

  // Write monitor.
  int   wr_cnt;
  int   last_wr_addr;
  int   last_wr_data;
  always @(posedge CLK) begin
    if (bus.MEM_WE) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= int'(bus.MEM_ADDR);
      last_wr_data <= int'(bus.MEM_WDATA);
    end
  end

  int n_checks;
  int n_fail;
  logic exp_ram [NUM_BLOCKS];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int n, output int ok);
    ok = 0;
    n  = 0;
    while (n < limit && ok == 0) begin
      @(negedge CLK);
      n++;
      if (bus.G_ACK) ok = 1;
    end
  endtask

  task automatic do_txn(input logic clr, input logic [ADDR_W-1:0] a,
                        output int alive, output int lat, output int wrs,
                        output int ok);
    int w0, n;
    w0 = wr_cnt;
    bus.G_REQ   = 1'b1;
    bus.G_CLEAR = clr;
    bus.G_ADDR  = a;
    wait_ack(40, n, ok);
    alive = int'(bus.G_ALIVE);
    lat   = n - 1;
    wrs   = wr_cnt - w0;
    bus.G_REQ = 1'b0;
  endtask

  typedef struct {
    logic              clr;
    logic [ADDR_W-1:0] addr;
    int                exp_alive;
    int                exp_lat;
    int                exp_wr;
    int                exp_cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int alive, lat, wrs, ok, n, w0;
    int bad, seen, cyc, pause_bad, hold_bad, dup, paused;
    logic [ADDR_W-1:0] cur;

    vecs[0] = '{1'b0, 7'd5,   1, 2, 0, 128};
    vecs[1] = '{1'b1, 7'd5,   1, 3, 1, 127};
    vecs[2] = '{1'b1, 7'd5,   0, 2, 0, 127};
    vecs[3] = '{1'b0, 7'd5,   0, 2, 0, 127};
    vecs[4] = '{1'b1, 7'd0,   1, 3, 1, 126};
    vecs[5] = '{1'b1, 7'd127, 1, 3, 1, 125};
    vecs[6] = '{1'b0, 7'd127, 0, 2, 0, 125};
    vecs[7] = '{1'b0, 7'd126, 1, 2, 0, 125};

    bus.IN_VBLANK  = 1'b1;
    bus.R_ADDR     = '0;
    bus.G_REQ      = 1'b0;
    bus.G_CLEAR    = 1'b0;
    bus.G_ADDR     = '0;
    bus.REFILL_REQ = 1'b0;

    // Reset values.
    repeat (3) @(negedge CLK);
    check("rst_g_ack", int'(bus.G_ACK), 0);
    check("rst_g_alive", int'(bus.G_ALIVE), 0);
    check("rst_mem_we", int'(bus.MEM_WE), 0);
    check("rst_busy", int'(bus.REFILL_BUSY), 1);
    check("rst_count", int'(bus.ALIVE_COUNT), 0);
    RESET = 1'b0;

    // Power-on refill: 128 consecutive writes of 1 at 0..127.
    n = 0;
    while (!bus.MEM_WE && n < 10) begin @(negedge CLK); n++; end
    check("init_refill_start", int'(bus.MEM_WE), 1);
    bad = 0;
    for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
      if (!bus.MEM_WE || int'(bus.MEM_ADDR) != i || !bus.MEM_WDATA) bad++;
      if (int'(bus.ALIVE_COUNT) != 0 || !bus.REFILL_BUSY) bad++;
      @(negedge CLK);
    end
    check("init_refill_seq_errors", bad, 0);
    check("init_refill_busy", int'(bus.REFILL_BUSY), 0);
    check("init_refill_count", int'(bus.ALIVE_COUNT), 128);
    check("init_refill_we_off", int'(bus.MEM_WE), 0);
    for (int i = 0; i < int'(NUM_BLOCKS); i++) exp_ram[i] = 1'b1;

    // Table of query/clear transactions.
    for (int v = 0; v < 8; v++) begin
      do_txn(vecs[v].clr, vecs[v].addr, alive, lat, wrs, ok);
      check($sformatf("vec%0d_ack", v), ok, 1);
      check($sformatf("vec%0d_alive", v), alive, vecs[v].exp_alive);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_writes", v), wrs, vecs[v].exp_wr);
      check($sformatf("vec%0d_count", v), int'(bus.ALIVE_COUNT), vecs[v].exp_cnt);
      if (vecs[v].exp_wr != 0) begin
        check($sformatf("vec%0d_wr_addr", v), last_wr_addr, int'(vecs[v].addr));
        check($sformatf("vec%0d_wr_data", v), last_wr_data, 0);
        exp_ram[vecs[v].addr] = 1'b0;
      end
      @(negedge CLK);
    end

    // Request outside vblank waits; renderer owns the RAM meanwhile.
    bus.IN_VBLANK = 1'b0;
    bus.G_REQ     = 1'b1;
    bus.G_CLEAR   = 1'b0;
    bus.G_ADDR    = 7'd10;
    cur = '0;
    bus.R_ADDR = cur;
    bad = 0;
    pause_bad = 0;
    hold_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (bus.MEM_ADDR != cur) bad++;
      if (i > 0 && bus.R_ALIVE != exp_ram[cur]) pause_bad++;
      if (bus.G_ACK || bus.MEM_WE) hold_bad++;
      cur = ADDR_W'($urandom_range(0, NUM_BLOCKS - 1));
      if (i % 7 == 0) cur = 7'd5;
      bus.R_ADDR = cur;
    end
    check("novb_mem_addr_errors", bad, 0);
    check("novb_r_alive_errors", pause_bad, 0);
    check("novb_ack_or_we_seen", hold_bad, 0);
    bus.IN_VBLANK = 1'b1;
    wait_ack(40, n, ok);
    check("novb_served_ack", ok, 1);
    check("novb_served_latency", n - 1, 2);
    check("novb_served_alive", int'(bus.G_ALIVE), 1);
    bus.G_REQ = 1'b0;
    @(negedge CLK);

    // Refill paused at index 60 by a vblank drop; repeat request ignored.
    bus.R_ADDR = 7'd33;
    bus.REFILL_REQ = 1'b1;
    @(negedge CLK);
    bus.REFILL_REQ = 1'b0;
    check("refill_busy_set", int'(bus.REFILL_BUSY), 1);
    seen = 0; cyc = 0; bad = 0; pause_bad = 0; hold_bad = 0; dup = 0; paused = 0;
    while (seen < int'(NUM_BLOCKS) && cyc < 600) begin
      if (bus.MEM_WE) begin
        if (int'(bus.MEM_ADDR) != seen || !bus.MEM_WDATA) bad++;
        seen++;
      end
      if (int'(bus.ALIVE_COUNT) != 125) hold_bad++;
      if (seen == 60 && paused == 0) begin
        paused = 1;
        bus.IN_VBLANK = 1'b0;
        repeat (20) begin
          @(negedge CLK);
          if (bus.MEM_WE || bus.MEM_ADDR != 7'd33 || !bus.REFILL_BUSY) pause_bad++;
          if (int'(bus.ALIVE_COUNT) != 125) hold_bad++;
        end
        bus.IN_VBLANK = 1'b1;
      end
      if (seen == 100 && dup == 0) begin
        dup = 1;
        bus.REFILL_REQ = 1'b1;
      end else begin
        bus.REFILL_REQ = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    bus.REFILL_REQ = 1'b0;
    check("pause_refill_writes", seen, 128);
    check("pause_refill_seq_errors", bad, 0);
    check("pause_refill_hold_errors", pause_bad, 0);
    check("pause_refill_count_held", hold_bad, 0);
    check("pause_refill_count", int'(bus.ALIVE_COUNT), 128);
    check("pause_refill_busy", int'(bus.REFILL_BUSY), 0);
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.MEM_WE || bus.REFILL_BUSY) bad++;
    end
    check("refill_no_restart", bad, 0);

    // Refill request latched during a clear transaction.
    w0 = wr_cnt;
    bus.G_REQ = 1'b1; bus.G_CLEAR = 1'b1; bus.G_ADDR = 7'd20;
    @(negedge CLK);
    bus.REFILL_REQ = 1'b1;
    @(negedge CLK);
    bus.REFILL_REQ = 1'b0;
    check("latched_refill_busy", int'(bus.REFILL_BUSY), 1);
    wait_ack(20, n, ok);
    check("latched_ack", ok, 1);
    check("latched_alive", int'(bus.G_ALIVE), 1);
    check("latched_count_dec", int'(bus.ALIVE_COUNT), 127);
    bus.G_REQ = 1'b0;
    n = 0;
    while (bus.REFILL_BUSY && n < 400) begin @(negedge CLK); n++; end
    check("latched_refill_done", int'(bus.REFILL_BUSY), 0);
    check("latched_refill_count", int'(bus.ALIVE_COUNT), 128);
    check("latched_total_writes", wr_cnt - w0, 129);

    // Simultaneous refill and clear: refill first.
    @(negedge CLK);
    w0 = wr_cnt;
    bus.REFILL_REQ = 1'b1;
    bus.G_REQ = 1'b1; bus.G_CLEAR = 1'b1; bus.G_ADDR = 7'd3;
    @(negedge CLK);
    bus.REFILL_REQ = 1'b0;
    wait_ack(400, n, ok);
    check("prio_ack", ok, 1);
    check("prio_alive", int'(bus.G_ALIVE), 1);
    check("prio_count", int'(bus.ALIVE_COUNT), 127);
    check("prio_writes", wr_cnt - w0, 129);
    check("prio_last_wr_addr", last_wr_addr, 3);
    check("prio_last_wr_data", last_wr_data, 0);
    bus.G_REQ = 1'b0;
    @(negedge CLK);

    // Request held across reset is served after the automatic refill.
    bus.IN_VBLANK = 1'b0;
    bus.G_REQ = 1'b1; bus.G_CLEAR = 1'b0; bus.G_ADDR = 7'd3;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst2_g_ack", int'(bus.G_ACK), 0);
    check("rst2_busy", int'(bus.REFILL_BUSY), 1);
    check("rst2_count", int'(bus.ALIVE_COUNT), 0);
    bus.IN_VBLANK = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    w0 = wr_cnt;
    wait_ack(400, n, ok);
    check("rst2_ack", ok, 1);
    check("rst2_alive", int'(bus.G_ALIVE), 1);
    check("rst2_writes", wr_cnt - w0, 128);
    check("rst2_count_after", int'(bus.ALIVE_COUNT), 128);
    bus.G_REQ = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
